// File: rtl/load_extend_ctrl_pkg.sv
// Shared load-type codes, FSM state encoding and access-size helpers
// for the load sequencer and the control-unit decoder.
package load_extend_ctrl_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unlisted encodings behave as a full word load.
  function automatic size_t load_size(input logic [2:0] lt);
    size_t sz;
    case (lt)
      LT_LB, LT_LBU: sz = SZ_BYTE;
      LT_LH, LT_LHU: sz = SZ_HALF;
      LT_LW:         sz = SZ_WORD;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] a);
    logic m;
    case (load_size(lt))
      SZ_HALF: m = a[0];
      SZ_WORD: m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/extend16.sv
// Widens a 16-bit value to 32 bits, sign- or zero-extending on request.
module extend16 (
  input  logic [15:0] a,
  input  logic        sign,
  output logic [31:0] b
);

  assign b = {{16{a[15] & sign}}, a};

endmodule

// File: rtl/load_extend_ctrl.sv
// Multi-cycle load sequencer: issues one word-aligned read per request, then
// lane-selects and extends the returned data, flagging misalignment and timeouts.
module load_extend_ctrl
  import load_extend_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  ltype,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] data_out,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [2:0]  ltype_r, ltype_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] data_out_r, data_out_s;
  logic [31:0] mem_addr_r;
  logic        busy_r, mem_rd_r, done_r, err_align_r, err_timeout_r;
  logic        align_s, timeout_s;

  logic [7:0]  byte_s;
  logic [15:0] half_s, ext_in_s;
  logic [31:0] ext_out_s, result_s;
  logic        sign_s;

  extend16 u_extend16 (
    .a    (ext_in_s),
    .sign (sign_s),
    .b    (ext_out_s)
  );

  // Lane select and byte pre-widening ahead of the shared extender.
  always_comb begin
    byte_s   = 8'h00;
    half_s   = 16'h0000;
    ext_in_s = 16'h0000;
    result_s = 32'h0000_0000;
    sign_s   = ~ltype_r[2];
    case (addr_r[1:0])
      2'b00:   byte_s = mem_rdata[7:0];
      2'b01:   byte_s = mem_rdata[15:8];
      2'b10:   byte_s = mem_rdata[23:16];
      default: byte_s = mem_rdata[31:24];
    endcase
    if (addr_r[1]) begin
      half_s = mem_rdata[31:16];
    end else begin
      half_s = mem_rdata[15:0];
    end
    case (load_size(ltype_r))
      SZ_BYTE: ext_in_s = {{8{byte_s[7] & sign_s}}, byte_s};
      SZ_HALF: ext_in_s = half_s;
      default: ext_in_s = half_s;
    endcase
    if (load_size(ltype_r) == SZ_WORD) begin
      result_s = mem_rdata;
    end else begin
      result_s = ext_out_s;
    end
  end

  // Next-state, request latching and completion bookkeeping.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ltype_s    = ltype_r;
    addr_s     = addr_r;
    data_out_s = data_out_r;
    align_s    = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          ltype_s = ltype;
          addr_s  = addr;
          cnt_s   = 8'd0;
          if (is_misaligned(ltype, addr[1:0])) begin
            align_s = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_s = cnt_r + 8'd1;
        // A returning read wins over a simultaneous timeout.
        if (mem_ready) begin
          data_out_s = result_s;
          state_s    = ST_DONE;
        end else if (cnt_r == LIMIT_M1) begin
          timeout_s  = 1'b1;
          data_out_s = 32'h0000_0000;
          state_s    = ST_DONE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 8'd0;
      ltype_r       <= 3'b000;
      addr_r        <= 32'h0000_0000;
      data_out_r    <= 32'h0000_0000;
      mem_addr_r    <= 32'h0000_0000;
      busy_r        <= 1'b0;
      mem_rd_r      <= 1'b0;
      done_r        <= 1'b0;
      err_align_r   <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      ltype_r       <= ltype_s;
      addr_r        <= addr_s;
      data_out_r    <= data_out_s;
      mem_addr_r    <= {addr_s[31:2], 2'b00};
      busy_r        <= (state_s != ST_IDLE);
      mem_rd_r      <= (state_s == ST_REQ);
      done_r        <= (state_s == ST_DONE);
      err_align_r   <= align_s;
      err_timeout_r <= timeout_s;
    end
  end

  assign busy        = busy_r;
  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign data_out    = data_out_r;
  assign done        = done_r;
  assign err_align   = err_align_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Self-checking bench for load_extend_ctrl: directed scenarios plus randomized
// loads compared against an arithmetic reference model.
module tb_load_extend_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  ltype = 3'b000;
  logic [31:0] addr = 32'h0;
  logic        busy, mem_rd, done, err_align, err_timeout;
  logic [31:0] mem_addr, data_out;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_dout;

  load_extend_ctrl #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ltype(ltype), .addr(addr),
    .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .data_out(data_out), .done(done),
    .err_align(err_align), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [2:0] lt);
    if (lt == 3'd0 || lt == 3'd4) return 1;
    if (lt == 3'd1 || lt == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] lt, input logic [31:0] a);
    return (a % size_of(lt)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint v;
    bit sgn;
    int sz;
    sz  = size_of(lt);
    sgn = (lt == 3'd0 || lt == 3'd1);
    if (sz == 4) return rd;
    v = (longint'(rd) >> (8 * (a % 4))) % (longint'(1) << (8 * sz));
    if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  // Issues one request and serves memory; ready arrives after rdy_delay read cycles (-1: never).
  task automatic run_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] rd,
                          input int rdy_delay, output int lat, output int rd_cycles,
                          output logic [31:0] maddr, output bit got_done);
    @(negedge clk);
    ltype = lt; addr = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; rd_cycles = 0; got_done = 1'b0; maddr = 32'h0;
    for (int c = 0; c < 64; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (mem_rd) begin
        rd_cycles++;
        maddr = mem_addr;
        if (rd_cycles - 1 == rdy_delay) begin
          mem_ready = 1'b1; mem_rdata = rd;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_rd, done, err_align, err_timeout} !== 5'b0 || data_out !== 32'h0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b data_out=%h mem_addr=%h, required 00000/0/0",
               {busy, mem_rd, done, err_align, err_timeout}, data_out, mem_addr);
    end
  endtask

  task automatic test_directed;
    logic [2:0]  lts [4] = '{3'd0, 3'd4, 3'd5, 3'd1};
    logic [31:0] ads [4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000};
    logic [31:0] exps[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'h0000_1234};
    int lat, rdc; logic [31:0] ma; bit gd;
    for (int i = 0; i < 4; i++) begin
      run_load(lts[i], ads[i], 32'h80FF_1234, 0, lat, rdc, ma, gd);
      n_checks++;
      if (!gd || lat != 2 || data_out !== exps[i] || ma !== 32'h1000 || err_align || err_timeout) begin
        n_fail++;
        $display("FAIL directed_%0d: done=%0d lat=%0d data_out=%h mem_addr=%h ea=%b et=%b, required lat=2 data_out=%h mem_addr=00001000 no errors",
                 i, gd, lat, data_out, ma, err_align, err_timeout, exps[i]);
      end
    end
    exp_dout = 32'h0000_1234;
  endtask

  task automatic test_align;
    int lat, rdc; logic [31:0] ma; bit gd;
    run_load(3'd1, 32'h1001, 32'hDEAD_BEEF, 0, lat, rdc, ma, gd);
    n_checks++;
    if (!gd || lat != 1 || rdc != 0 || err_align !== 1'b1 || err_timeout !== 1'b0 || data_out !== exp_dout) begin
      n_fail++;
      $display("FAIL misaligned_lh: done=%0d lat=%0d rd_cycles=%0d ea=%b et=%b data_out=%h, required lat=1 rd=0 ea=1 et=0 data_out=%h",
               gd, lat, rdc, err_align, err_timeout, data_out, exp_dout);
    end
  endtask

  task automatic test_timeout;
    int lat, rdc; logic [31:0] ma; bit gd;
    run_load(3'd3, 32'h2000, 32'h1234_5678, -1, lat, rdc, ma, gd);
    n_checks++;
    if (!gd || rdc != 16 || lat != 17 || err_timeout !== 1'b1 || err_align !== 1'b0 || data_out !== 32'h0 || ma !== 32'h2000) begin
      n_fail++;
      $display("FAIL timeout_lw: done=%0d rd_cycles=%0d lat=%0d et=%b ea=%b data_out=%h mem_addr=%h, required rd=16 lat=17 et=1 ea=0 data_out=0 mem_addr=00002000",
               gd, rdc, lat, err_timeout, err_align, data_out, ma);
    end
    exp_dout = 32'h0;
  endtask

  task automatic test_reset_mid;
    int lat, rdc; logic [31:0] ma, rd; bit gd, saw_done;
    @(negedge clk);
    ltype = 3'd3; addr = 32'h3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b mem_rd=%b done=%b, required all 0", busy, mem_rd, done);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: done/busy=1 after reset, required 0");
    end
    exp_dout = 32'h0;
    rd = $urandom;
    run_load(3'd3, 32'h3004, rd, 2, lat, rdc, ma, gd);
    n_checks++;
    if (!gd || lat != 4 || data_out !== rd || ma !== 32'h3004) begin
      n_fail++;
      $display("FAIL reset_recover: done=%0d lat=%0d data_out=%h mem_addr=%h, required lat=4 data_out=%h mem_addr=00003004",
               gd, lat, data_out, ma, rd);
    end
    exp_dout = rd;
  endtask

  task automatic test_ignore;
    logic [31:0] rd, want;
    rd = $urandom;
    want = model_load(3'd0, 32'h4001, rd);
    @(negedge clk);
    ltype = 3'd0; addr = 32'h4001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ltype = 3'd3; addr = 32'h5002; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err_align !== 1'b0 || data_out !== want || mem_addr !== 32'h4000) begin
      n_fail++;
      $display("FAIL ignore_busy_start: done=%b ea=%b data_out=%h mem_addr=%h, required done=1 ea=0 data_out=%h mem_addr=00004000",
               done, err_align, data_out, mem_addr, want);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_done_start: busy=%b done=%b, required 0/0", busy, done);
    end
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0 || data_out !== want) begin
      n_fail++;
      $display("FAIL ignore_idle_ready: busy=%b mem_rd=%b done=%b data_out=%h, required 0/0/0 data_out=%h",
               busy, mem_rd, done, data_out, want);
    end
    exp_dout = want;
  endtask

  task automatic test_random;
    int lat, rdc, dly; logic [31:0] ma, rd, a, want; logic [2:0] lt; bit gd, mis;
    for (int i = 0; i < 40; i++) begin
      lt = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      rd = $urandom;
      dly = $urandom_range(0, 5);
      mis = model_mis(lt, a);
      want = mis ? exp_dout : model_load(lt, a, rd);
      run_load(lt, a, rd, dly, lat, rdc, ma, gd);
      n_checks++;
      if (mis) begin
        if (!gd || lat != 1 || rdc != 0 || err_align !== 1'b1 || data_out !== want) begin
          n_fail++;
          $display("FAIL random_%0d_mis: lt=%0d a=%h lat=%0d rd=%0d ea=%b data_out=%h, required lat=1 rd=0 ea=1 data_out=%h",
                   i, lt, a, lat, rdc, err_align, data_out, want);
        end
      end else begin
        if (!gd || lat != dly + 2 || rdc != dly + 1 || err_align || err_timeout ||
            data_out !== want || ma !== (a & 32'hFFFF_FFFC)) begin
          n_fail++;
          $display("FAIL random_%0d: lt=%0d a=%h rdata=%h lat=%0d rd=%0d data_out=%h mem_addr=%h, required lat=%0d rd=%0d data_out=%h",
                   i, lt, a, rd, lat, rdc, data_out, ma, dly + 2, dly + 1, want);
        end
      end
      exp_dout = want;
    end
  endtask

  initial begin
    exp_dout = 32'h0;
    test_reset();
    test_directed();
    test_align();
    test_timeout();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
